// File: rtl/desired_drive_pipe_if.sv
// Sample/result bundle for desired_drive_pipe: the sensor side drives the sample fields,
// and the pipe drives the target current, its valid pulse and the saturation flag.
interface desired_drive_pipe_if #(
  parameter int TQ_W  = 12,
  parameter int INC_W = 13,
  parameter int CAD_W = 5,
  parameter int SCL_W = 3,
  parameter int OUT_W = 12
);
  logic                    in_vld;
  logic [TQ_W-1:0]         avg_torque;
  logic [CAD_W-1:0]        cadence;
  logic                    not_pedaling;
  logic signed [INC_W-1:0] incline;
  logic [SCL_W-1:0]        scale;
  logic [OUT_W-1:0]        target_curr;
  logic                    out_vld;
  logic                    sat;

  modport master (
    output in_vld, avg_torque, cadence, not_pedaling, incline, scale,
    input  target_curr, out_vld, sat
  );

  modport slave (
    input  in_vld, avg_torque, cadence, not_pedaling, incline, scale,
    output target_curr, out_vld, sat
  );
endinterface

// File: rtl/desired_drive_pipe.sv
// Six-register valid-qualified pipeline mapping torque/incline/cadence/scale to a target current.
// Define TGT_SLEW_EN to limit rising target current to SLEW_UP per update.
module desired_drive_pipe #(
  parameter int              TQ_W       = 12,
  parameter logic [TQ_W-1:0] TORQUE_MIN = 12'h380,
  parameter int              INC_W      = 13,
  parameter int              CAD_W      = 5,
  parameter int              SCL_W      = 3,
  parameter int              OUT_W      = 12,
  parameter int              SHIFT      = 15
`ifdef TGT_SLEW_EN
  , parameter logic [OUT_W-1:0] SLEW_UP = 12'h040
`endif
) (
  input logic           clk,
  input logic           rst_n,
  desired_drive_pipe_if.slave pipe_if
);

  localparam int P1_W = TQ_W + 9;
  localparam int P2_W = P1_W + CAD_W + 1;
  localparam int PW   = P2_W + SCL_W;
  localparam logic signed [INC_W-1:0] INC_HI = INC_W'(511);
  localparam logic signed [INC_W-1:0] INC_LO = INC_W'(-512);

  logic                vld0_q, vld1_q, vld2_q, vld3_q, vld4_q, out_vld_q;
  logic [TQ_W-1:0]     tq0_q;
  logic [8:0]          incl0_q;
  logic [CAD_W:0]      cad0_q, cad1_q;
  logic [SCL_W-1:0]    scl0_q, scl1_q, scl2_q;
  logic                np0_q, np1_q, np2_q, np3_q;
  logic [P1_W-1:0]     p1_q;
  logic [P2_W-1:0]     p2_q;
  logic [PW-1:0]       p3_q;
  logic [OUT_W-1:0]    r4_q, target_q;
  logic                sat4_q, sat_q;

  logic signed [9:0]   incSat_d;
  logic signed [10:0]  inclSum_d;
  logic [8:0]          incl_d;
  logic [TQ_W-1:0]     tq_d;
  logic [CAD_W:0]      cad_d;
  logic [PW-1:0]       rFull_d;
  logic                rOver_d;
  logic [OUT_W-1:0]    r4_d, target_d;
  logic                sat4_d;

  // Input conditioning: incline is clamped twice so the offset add can never wrap.
  always_comb begin
    if ($signed(pipe_if.incline) > INC_HI)      incSat_d = 10'b01_1111_1111;
    else if ($signed(pipe_if.incline) < INC_LO) incSat_d = 10'b10_0000_0000;
    else                                        incSat_d = pipe_if.incline[9:0];
    inclSum_d = 11'(incSat_d) + 11'sd256;
    if (inclSum_d[10])              incl_d = '0;
    else if (inclSum_d > 11'sd511)  incl_d = 9'd511;
    else                            incl_d = inclSum_d[8:0];
    tq_d  = (pipe_if.avg_torque > TORQUE_MIN) ? pipe_if.avg_torque - TORQUE_MIN : '0;
    cad_d = (pipe_if.cadence > CAD_W'(1)) ? (CAD_W+1)'(pipe_if.cadence) + (CAD_W+1)'(32) : '0;
  end

  // Not-pedaling forces a clean zero with no saturation report.
  always_comb begin
    rFull_d = p3_q >> SHIFT;
    rOver_d = |(rFull_d >> OUT_W);
    if (np3_q) begin
      r4_d   = '0;
      sat4_d = 1'b0;
    end else begin
      r4_d   = rOver_d ? '1 : rFull_d[OUT_W-1:0];
      sat4_d = rOver_d;
    end
  end

`ifdef TGT_SLEW_EN
  logic [OUT_W:0]   slewSum_d;
  logic [OUT_W-1:0] slewLim_d;

  // Rising steps are capped relative to the current output; falls pass straight through.
  always_comb begin
    slewSum_d = {1'b0, target_q} + {1'b0, SLEW_UP};
    slewLim_d = slewSum_d[OUT_W] ? '1 : slewSum_d[OUT_W-1:0];
    target_d  = (r4_q < slewLim_d) ? r4_q : slewLim_d;
  end
`else
  always_comb begin
    target_d = r4_q;
  end
`endif

  // Valid bits always advance; data registers load only behind a set valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld0_q <= 1'b0; vld1_q <= 1'b0; vld2_q <= 1'b0;
      vld3_q <= 1'b0; vld4_q <= 1'b0; out_vld_q <= 1'b0;
      tq0_q <= '0; incl0_q <= '0; cad0_q <= '0; scl0_q <= '0; np0_q <= 1'b0;
      p1_q <= '0; cad1_q <= '0; scl1_q <= '0; np1_q <= 1'b0;
      p2_q <= '0; scl2_q <= '0; np2_q <= 1'b0;
      p3_q <= '0; np3_q <= 1'b0;
      r4_q <= '0; sat4_q <= 1'b0;
      target_q <= '0; sat_q <= 1'b0;
    end else begin
      vld0_q    <= pipe_if.in_vld;
      vld1_q    <= vld0_q;
      vld2_q    <= vld1_q;
      vld3_q    <= vld2_q;
      vld4_q    <= vld3_q;
      out_vld_q <= vld4_q;
      if (pipe_if.in_vld) begin
        tq0_q   <= tq_d;
        incl0_q <= incl_d;
        cad0_q  <= cad_d;
        scl0_q  <= pipe_if.scale;
        np0_q   <= pipe_if.not_pedaling;
      end
      if (vld0_q) begin
        p1_q   <= P1_W'(tq0_q) * P1_W'(incl0_q);
        cad1_q <= cad0_q;
        scl1_q <= scl0_q;
        np1_q  <= np0_q;
      end
      if (vld1_q) begin
        p2_q   <= P2_W'(p1_q) * P2_W'(cad1_q);
        scl2_q <= scl1_q;
        np2_q  <= np1_q;
      end
      if (vld2_q) begin
        p3_q  <= PW'(p2_q) * PW'(scl2_q);
        np3_q <= np2_q;
      end
      if (vld3_q) begin
        r4_q   <= r4_d;
        sat4_q <= sat4_d;
      end
      if (vld4_q) begin
        target_q <= target_d;
        sat_q    <= sat4_q;
      end
    end
  end

  assign pipe_if.target_curr = target_q;
  assign pipe_if.out_vld     = out_vld_q;
  assign pipe_if.sat         = sat_q;

endmodule

// File: tb/tb_desired_drive_pipe.sv
// Scoreboard bench for desired_drive_pipe: directed cases, a mid-flight reset and random samples
// checked against an arithmetic reference model (follows TGT_SLEW_EN when defined).
module tb_desired_drive_pipe;

  typedef struct {
    int target;
    bit satV;
    int edgeNo;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   cycle = 0;
  int   modelTarget = 0;
  int   lastTarget = 0;
  bit   lastSat = 1'b0;
  exp_t expQ[$];
  exp_t popped;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  desired_drive_pipe_if pipeIf();

  desired_drive_pipe dut (
    .clk(clk),
    .rst_n(rst_n),
    .pipe_if(pipeIf)
  );

  task automatic checkOutput(input string name, input int got, input int expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", name, got, expv);
    end
  endtask

  function automatic void refModel(input int tq, input int inc, input int cad, input int scl,
                                   input bit np, output int r, output bit s);
    longint t, i, c, p;
    i = inc;
    if (i > 511)  i = 511;
    if (i < -512) i = -512;
    i = i + 256;
    if (i < 0)   i = 0;
    if (i > 511) i = 511;
    t = (tq > 'h380) ? tq - 'h380 : 0;
    c = (cad > 1) ? cad + 32 : 0;
    p = t * i * c * longint'(scl);
    r = int'(p >> 15);
    s = 1'b0;
    if (r > 4095) begin
      r = 4095;
      s = 1'b1;
    end
    if (np) begin
      r = 0;
      s = 1'b0;
    end
  endfunction

  // Drives one sample for exactly one clock; called right after a falling edge.
  task automatic applyStimulus(input logic [11:0] tq, input logic signed [12:0] inc,
                               input logic [4:0] cad, input logic [2:0] scl, input logic np);
    int r;
    bit s;
    pipeIf.in_vld       = 1'b1;
    pipeIf.avg_torque   = tq;
    pipeIf.incline      = inc;
    pipeIf.cadence      = cad;
    pipeIf.scale        = scl;
    pipeIf.not_pedaling = np;
    refModel(int'(tq), int'(inc), int'(cad), int'(scl), np, r, s);
`ifdef TGT_SLEW_EN
    if (r > modelTarget + 64) r = (modelTarget + 64 > 4095) ? 4095 : modelTarget + 64;
`endif
    modelTarget = r;
    expQ.push_back('{target: r, satV: s, edgeNo: cycle + 1});
    @(negedge clk);
    pipeIf.in_vld = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) begin
      pipeIf.in_vld     = 1'b0;
      pipeIf.avg_torque = 12'($urandom_range(0, 4095));
      pipeIf.scale      = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
  endtask

  task automatic resetPulse();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_target", int'(pipeIf.target_curr), 0);
    checkOutput("async_reset_vld", int'(pipeIf.out_vld), 0);
    checkOutput("async_reset_sat", int'(pipeIf.sat), 0);
    expQ.delete();
    modelTarget = 0;
    lastTarget  = 0;
    lastSat     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pops on every out_vld, otherwise checks that outputs hold.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pipeIf.out_vld) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_out_vld", 1, 0);
        end else begin
          popped = expQ.pop_front();
          checkOutput("latency", cycle - popped.edgeNo, 5);
          checkOutput("target_curr", int'(pipeIf.target_curr), popped.target);
          checkOutput("sat", int'(pipeIf.sat), int'(popped.satV));
          lastTarget = popped.target;
          lastSat    = popped.satV;
        end
      end else begin
        checkOutput("hold_target", int'(pipeIf.target_curr), lastTarget);
        checkOutput("hold_sat", int'(pipeIf.sat), int'(lastSat));
      end
    end
  end

  initial begin
    rst_n               = 1'b0;
    pipeIf.in_vld       = 1'b0;
    pipeIf.avg_torque   = '0;
    pipeIf.incline      = '0;
    pipeIf.cadence      = '0;
    pipeIf.scale        = '0;
    pipeIf.not_pedaling = 1'b0;
    #12;
    checkOutput("reset_target", int'(pipeIf.target_curr), 0);
    checkOutput("reset_vld", int'(pipeIf.out_vld), 0);
    checkOutput("reset_sat", int'(pipeIf.sat), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(12'h480, 13'sh0000, 5'd8, 3'd4, 1'b0);
    idleCycles(8);
    applyStimulus(12'hFFF, 13'sh00FF, 5'd31, 3'd7, 1'b0);
    idleCycles(8);
    applyStimulus(12'h480, 13'sh1F00, 5'd8, 3'd4, 1'b0);
    applyStimulus(12'h480, 13'sh0000, 5'd1, 3'd4, 1'b0);
    applyStimulus(12'h37F, 13'sh0000, 5'd8, 3'd4, 1'b0);
    applyStimulus(12'h480, 13'sh0000, 5'd8, 3'd4, 1'b1);
    idleCycles(8);

    applyStimulus(12'h480, 13'sh0000, 5'd8, 3'd4, 1'b0);
    applyStimulus(12'hFFF, 13'sh00FF, 5'd31, 3'd7, 1'b0);
    applyStimulus(12'h480, 13'sh0000, 5'd8, 3'd4, 1'b0);
    applyStimulus(12'hFFF, 13'sh00FF, 5'd31, 3'd7, 1'b1);
    applyStimulus(12'hFFF, 13'sh00FF, 5'd31, 3'd7, 1'b0);
    applyStimulus(12'h480, 13'sh0000, 5'd8, 3'd4, 1'b0);
    idleCycles(8);

    applyStimulus(12'h480, 13'sh0000, 5'd8, 3'd4, 1'b0);
    applyStimulus(12'hFFF, 13'sh00FF, 5'd31, 3'd7, 1'b0);
    applyStimulus(12'h480, 13'sh0000, 5'd8, 3'd4, 1'b0);
    resetPulse();
    idleCycles(10);

    for (int k = 0; k < 6; k++) begin
      applyStimulus(12'h480, 13'sh0000, 5'd8, 3'd4, 1'b0);
      idleCycles(2);
    end
    applyStimulus(12'h480, 13'sh0000, 5'd8, 3'd0, 1'b0);
    idleCycles(8);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        idleCycles(int'($urandom_range(1, 3)));
      end else begin
        applyStimulus(12'($urandom_range(0, 4095)), 13'($urandom_range(0, 8191)),
                      5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                      ($urandom_range(0, 7) == 0));
      end
    end

    for (int k = 0; k < 20 && expQ.size() != 0; k++) @(negedge clk);
    if (expQ.size() != 0) checkOutput("drain_timeout", expQ.size(), 0);
    idleCycles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
